// File: rtl/mdu_pipe_unit.sv
// rtl/mdu_pipe_unit.sv - multiply/divide unit with HI/LO, fixed-latency long ops, MADD/MSUB and flush
module mdu_pipe_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   temp;
    logic [2*WIDTH-1:0]   acc, se1, se2, ze1, ze2, prod_s, prod_u, res;
    logic                 is_long, is_div, div_zero, div_ovf;
    logic signed [WIDTH-1:0] s_dividend, s_divisor;
    logic [WIDTH-1:0]     u_divisor, q_s, r_s, q_u, r_u;

    assign is_long = (op >= OP_MULT && op <= OP_DIVU) || (op >= OP_MADD && op <= OP_MSUBU);
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);

    assign acc    = {hi, lo};
    assign se1    = {{WIDTH{d1[WIDTH-1]}}, d1};
    assign se2    = {{WIDTH{d2[WIDTH-1]}}, d2};
    assign ze1    = {{WIDTH{1'b0}}, d1};
    assign ze2    = {{WIDTH{1'b0}}, d2};
    assign prod_s = se1 * se2;
    assign prod_u = ze1 * ze2;

    // Special divide cases are muxed in below; the divider sees a harmless divisor of 1 instead.
    assign div_zero   = (d2 == '0);
    assign div_ovf    = (d1 == {1'b1, {(WIDTH-1){1'b0}}}) && (d2 == '1);
    assign s_dividend = d1;
    assign s_divisor  = (div_zero || div_ovf) ? WIDTH'(1) : d2;
    assign u_divisor  = div_zero ? WIDTH'(1) : d2;
    assign q_s        = s_dividend / s_divisor;
    assign r_s        = s_dividend % s_divisor;
    assign q_u        = d1 / u_divisor;
    assign r_u        = d1 % u_divisor;

    always_comb begin
        res = acc;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
            OP_DIV: begin
                if (div_zero)     res = {d1, {WIDTH{1'b1}}};
                else if (div_ovf) res = {{WIDTH{1'b0}}, d1};
                else              res = {r_s, q_s};
            end
            OP_DIVU: begin
                if (div_zero) res = {d1, {WIDTH{1'b1}}};
                else          res = {r_u, q_u};
            end
            default: res = acc;
        endcase
    end

    always_comb begin
        out = '0;
        if (op == OP_MFHI)      out = hi;
        else if (op == OP_MFLO) out = lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            temp  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush && is_long) begin
                        temp  <= res;
                        cnt   <= is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
                        busy  <= 1'b1;
                        state <= BUSY;
                    end else if (op == OP_MTHI) begin
                        hi <= d1;
                    end else if (op == OP_MTLO) begin
                        lo <= d1;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        {hi, lo} <= temp;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_pipe_unit.sv
// tb/tb_mdu_pipe_unit.sv - table-driven and sequence checks for mdu_pipe_unit
module tb_mdu_pipe_unit;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;
    localparam logic [3:0] MADD = 4'd9, MADDU = 4'd10, MSUB = 4'd11, MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  op = 4'd0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        busy, done;
    logic [31:0] out, hi, lo;

    int checks = 0;
    int errors = 0;

    mdu_pipe_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .flush(flush),
        .d1(d1), .d2(d2), .busy(busy), .done(done), .out(out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic s, input logic f,
                         input logic [31:0] a, input logic [31:0] b);
        op = o; start = s; flush = f; d1 = a; d2 = b;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        drive(MTHI, 1'b0, 1'b0, h, '0); tick();
        drive(MTLO, 1'b0, 1'b0, l, '0); tick();
        drive(NONE, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic run_vec(input int i);
        int  cnt;
        logic dseen;
        preload(vecs[i].pre_hi, vecs[i].pre_lo);
        drive(vecs[i].op, 1'b1, 1'b0, vecs[i].a, vecs[i].b);
        tick();
        drive(NONE, 1'b0, 1'b0, '0, '0);
        cnt = 0;
        dseen = 1'b0;
        while (busy && cnt < 200) begin
            cnt++;
            if (done) dseen = 1'b1;
            tick();
        end
        chk($sformatf("vec%0d busy_cycles", i), 32'(cnt), 32'(vecs[i].lat));
        chk($sformatf("vec%0d done_while_busy", i), {31'b0, dseen}, 32'd0);
        chk($sformatf("vec%0d done_pulse", i), {31'b0, done}, 32'd1);
        chk($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
        chk($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
        tick();
        chk($sformatf("vec%0d done_clear", i), {31'b0, done}, 32'd0);
    endtask

    initial begin
        int   cnt;
        logic dseen;

        vecs[0]  = '{MULT,  32'hFFFFFFFF, 32'd2,          32'd0, 32'd0,  32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'd2,          32'd0, 32'd0,  32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,          32'd0, 32'd0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{DIVU,  32'd7,        32'd0,          32'd0, 32'd0,  32'h00000007, 32'hFFFFFFFF, 10};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF,   32'd9, 32'd9,  32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{MADD,  32'd2,        32'd4,          32'd5, 32'd3,  32'd5,        32'd11,       5};
        vecs[6]  = '{MSUBU, 32'd1,        32'd12,         32'd5, 32'd11, 32'd4,        32'hFFFFFFFF, 5};
        vecs[7]  = '{DIV,   32'hFFFFFFF7, 32'd0,          32'd0, 32'd0,  32'hFFFFFFF7, 32'hFFFFFFFF, 10};
        vecs[8]  = '{MSUB,  32'd3,        32'hFFFFFFFF,   32'd0, 32'd0,  32'd0,        32'd3,        5};
        vecs[9]  = '{MADDU, 32'd1,        32'd1,          32'd0, 32'hFFFFFFFF, 32'd1,  32'd0,        5};
        vecs[10] = '{DIV,   32'd7,        32'hFFFFFFFE,   32'd0, 32'd0,  32'd1,        32'hFFFFFFFD, 10};
        vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'd2,          32'd0, 32'd0,  32'd1,        32'h7FFFFFFF, 10};
        vecs[12] = '{MULT,  32'hFFFFFFFD, 32'hFFFFFFFD,   32'd0, 32'd0,  32'd0,        32'd9,        5};

        // Power-on reset
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst out", out, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(i);

        // Reset mid-MULT aborts with no commit
        preload(32'h11, 32'h22);
        drive(MULT, 1'b1, 1'b0, 32'd7, 32'd6);
        tick();
        drive(NONE, 1'b0, 1'b0, '0, '0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        reset = 1'b0;
        dseen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy) dseen = 1'b1;
        end
        chk("midrst no_commit", {31'b0, dseen}, 32'd0);
        chk("midrst lo_after", lo, 32'd0);

        // Flush a DIV at busy cycle 4, then a fresh MULT
        preload(32'hA, 32'hB);
        drive(DIV, 1'b1, 1'b0, 32'd100, 32'd3);
        tick();
        drive(NONE, 1'b0, 1'b0, '0, '0);
        chk("flush busy1", {31'b0, busy}, 32'd1);
        tick(); tick(); tick();
        chk("flush busy4", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy_drop", {31'b0, busy}, 32'd0);
        chk("flush hi", hi, 32'hA);
        chk("flush lo", lo, 32'hB);
        drive(MULT, 1'b1, 1'b0, 32'd3, 32'd3);
        tick();
        drive(NONE, 1'b0, 1'b0, '0, '0);
        cnt = 0;
        dseen = 1'b0;
        while (busy && cnt < 200) begin
            cnt++;
            if (done) dseen = 1'b1;
            tick();
        end
        chk("flush no_done", {31'b0, dseen}, 32'd0);
        chk("flush mult_cycles", 32'(cnt), 32'd5);
        chk("flush mult_lo", lo, 32'd9);
        chk("flush mult_hi", hi, 32'd0);
        chk("flush mult_done", {31'b0, done}, 32'd1);

        // MTHI and a second start while busy are ignored; start on commit edge ignored
        preload(32'h77, 32'h0);
        drive(MULT, 1'b1, 1'b0, 32'h10000, 32'h10000);
        tick();
        drive(MTHI, 1'b0, 1'b0, 32'h55, '0);
        tick();
        chk("busy mthi_ignored", hi, 32'h77);
        drive(MFHI, 1'b0, 1'b0, '0, '0);
        #1;
        chk("busy mfhi_old", out, 32'h77);
        drive(MULTU, 1'b1, 1'b0, 32'd2, 32'd2);
        tick(); tick();
        chk("busy still", {31'b0, busy}, 32'd1);
        tick(); tick();
        chk("commit busy", {31'b0, busy}, 32'd0);
        chk("commit done", {31'b0, done}, 32'd1);
        chk("commit hi", hi, 32'd1);
        chk("commit lo", lo, 32'd0);
        drive(MFHI, 1'b0, 1'b0, '0, '0);
        #1;
        chk("commit mfhi", out, 32'd1);
        drive(MFLO, 1'b0, 1'b0, '0, '0);
        #1;
        chk("commit mflo", out, 32'd0);
        tick();
        chk("commit no_restart", {31'b0, busy}, 32'd0);
        chk("commit done_clear", {31'b0, done}, 32'd0);

        // MTLO with flush high in idle still writes
        drive(MTLO, 1'b0, 1'b1, 32'h1234, '0);
        tick();
        drive(NONE, 1'b0, 1'b0, '0, '0);
        chk("idle mtlo_flush", lo, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_pipe_unit.md
Name: mdu_pipe_unit

Overview:
- Parametrised multiply/divide unit for the CPU execute stage. Holds the architectural HI/LO registers and runs multi-cycle MULT/DIV-class operations with a fixed, configurable latency.
- Adds three features over the previous generation: multiply-accumulate/subtract (MADD/MADDU/MSUB/MSUBU), defined divide-by-zero and overflow results, and a flush input that cancels an in-flight operation on exception.
- The pipeline stalls on `busy`, or on any MDU op issued while `busy` is high.

Parameters:
- WIDTH, 32: operand, HI and LO width.
- MULT_LAT, 5: cycles `busy` stays high for multiply-class ops. Must be ≥ 1.
- DIV_LAT, 10: cycles `busy` stays high for divide-class ops. Must be ≥ 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  4  operation code:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
  - 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU
  - 13–15 treated as NONE.
- start  in  1  qualifies `op` classes 1–4 and 9–12 (long ops).
- flush  in  1  cancels any in-flight long op; blocks a start on the same edge.
- d1  in  WIDTH  rs operand (dividend, multiplicand, MT source).
- d2  in  WIDTH  rt operand (divisor, multiplier).
- busy  out  1  long op in flight.
- done  out  1  one-cycle pulse after a commit to HI/LO.
- out  out  WIDTH  combinational read: HI when op=MFHI, LO when op=MFLO, else 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: asynchronous, takes effect immediately. Sets hi=0, lo=0, busy=0, done=0, counter=0, temp result=0, state=IDLE. Reset during an op aborts it with no commit.
- FSM has two states, IDLE and BUSY.
- IDLE, edge with start=1, flush=0 and op a long op:
  - Compute the 2*WIDTH result from d1/d2 (and current {hi,lo} for accumulate ops) into the temp register.
  - Load counter with LAT-1 (MULT_LAT or DIV_LAT); set busy=1; go to BUSY.
- IDLE, edge with start=0 or flush=1: MTHI writes hi<=d1 and MTLO writes lo<=d1. These need no start and are single-cycle; busy stays 0.
- BUSY, each edge:
  - flush=1 → busy<=0, go to IDLE, temp discarded, hi/lo unchanged, done stays 0.
  - else if counter==0 → {hi,lo}<=temp, busy<=0, done<=1 for the next cycle, go to IDLE.
  - else → counter decrements.
- Timing: a start sampled at edge N drops busy and makes the new hi/lo visible from edge N+LAT. busy is high for exactly LAT cycles.
- Start, MTHI and MTLO while busy=1 are ignored; the pipeline must stall.
- A start on the commit edge is ignored; it may be accepted on the next edge.
- MFHI/MFLO are combinational and return the current registers. During busy they return the pre-op values.
- Arithmetic:
  - MULT: signed product into {hi,lo}. MULTU: unsigned product into {hi,lo}.
  - MADD/MSUB: {hi,lo} ± signed product, modulo 2^(2*WIDTH).
  - MADDU/MSUBU: same with the unsigned product.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero (DIV or DIVU, d2=0): lo = all ones, hi = d1, still after DIV_LAT cycles.
- Signed overflow (DIV, d1 = -2^(WIDTH-1), d2 = -1): lo = d1, hi = 0.
- done is 0 in every cycle except the one after a commit; it is never asserted after a flush.

Test Plan:
- Reset mid-MULT: start MULT 7×6, assert reset at cycle 2 → busy=0, hi=lo=0 immediately; no commit at cycle 5.
- MULT 0xFFFFFFFF × 2 (signed) → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7 / 2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 → lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- MTHI 5, MTLO 3, then MADD 2×4 → hi=5, lo=11. Then MSUBU 1×12 → hi=4, lo=0xFFFFFFFF.
- Start DIV 100/3, flush at busy cycle 4 → busy=0 next edge, hi/lo keep old values, done never asserts. A new MULT 3×3 started the next cycle → lo=9 after 5 cycles.
- While a MULT is busy: issue MTHI 0x55 and a second start → both ignored. MFHI returns the old hi until commit, then the product's hi.
